// File: rtl/risc_v_prefetch_buffer_pkg.sv
// Shared types and constants for the RV32I instruction-fetch front end.
// Holds the default FIFO entry layout, the reset PC and the canonical NOP encoding.
package risc_v_pkg;

  localparam int XLEN = 32;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
    logic            err;
  } fetch_entry_t;

endpackage

// File: rtl/risc_v_prefetch_buffer_fifo.sv
// Generic synchronous FIFO with a type-parametrised entry and a synchronous flush.
// DEPTH must be a power of two so that the pointers wrap naturally.
module prefetch_fifo
  import risc_v_pkg::*;
#(
  parameter int  DEPTH   = 4,
  parameter type entry_t = fetch_entry_t,
  localparam int PTR_W   = $clog2(DEPTH)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           flush,
  input  logic           push,
  input  entry_t         push_data,
  input  logic           pop,
  output entry_t         head,
  output logic [PTR_W:0] count,
  output logic           full,
  output logic           empty
);

  entry_t           mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [PTR_W:0]   count_r;
  logic             push_ok_s;
  logic             pop_ok_s;

  assign full      = (count_r == (PTR_W+1)'(DEPTH));
  assign empty     = (count_r == '0);
  assign count     = count_r;
  assign head      = mem_r[rd_ptr_r];
  // A full FIFO may still accept a push when the head leaves in the same cycle.
  assign pop_ok_s  = pop && !empty;
  assign push_ok_s = push && (!full || pop_ok_s);

  // Entry storage
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else if (push_ok_s && !flush) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  // Pointers and occupancy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else if (flush) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + (PTR_W+1)'(1);
        2'b01:   count_r <= count_r - (PTR_W+1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/risc_v_prefetch_buffer.sv
// Decoupled RV32I instruction prefetcher: fetch PC, instruction FIFO, redirect flush
// and a sticky stop after a bus error that only a redirect clears.
module risc_v_prefetch_buffer
  import risc_v_pkg::*;
#(
  parameter int              DEPTH    = 4,
  parameter int              ADDR_W   = 32,
  parameter int              DATA_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(risc_v_pkg::RESET_PC)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     fetch_enable,
  input  logic                     halt,
  input  logic                     redirect_valid,
  input  logic [ADDR_W-1:0]        redirect_pc,
  output logic                     imem_req,
  output logic [ADDR_W-1:0]        imem_addr,
  input  logic [DATA_W-1:0]        imem_rdata,
  input  logic                     imem_ready,
  input  logic                     imem_err,
  output logic                     fetch_valid,
  output logic [DATA_W-1:0]        fetch_instr,
  output logic [ADDR_W-1:0]        fetch_pc,
  output logic                     fetch_err,
  input  logic                     fetch_ready,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] instr;
    logic              err;
  } entry_t;

  logic [ADDR_W-1:0] pc_r;
  logic              err_stop_r;
  logic              req_s;
  logic              xfer_s;
  logic              pop_s;
  logic              full_s;
  logic              empty_s;
  entry_t            push_data_s;
  entry_t            head_s;

  // Occupancy is the registered count only, so fetch_ready never reaches imem_req.
  assign req_s       = !rst && fetch_enable && !halt && !err_stop_r && !redirect_valid && !full_s;
  assign xfer_s      = req_s && imem_ready;
  assign pop_s       = !redirect_valid && !empty_s && fetch_ready;
  assign push_data_s = '{pc: pc_r, instr: imem_rdata, err: imem_err};

  assign imem_req    = req_s;
  assign imem_addr   = pc_r;
  assign fetch_valid = !empty_s;

  prefetch_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect_valid),
    .push      (xfer_s),
    .push_data (push_data_s),
    .pop       (pop_s),
    .head      (head_s),
    .count     (fifo_count),
    .full      (full_s),
    .empty     (empty_s)
  );

  // Head fields read zero while the FIFO is empty
  always_comb begin
    fetch_instr = '0;
    fetch_pc    = '0;
    fetch_err   = 1'b0;
    if (!empty_s) begin
      fetch_instr = head_s.instr;
      fetch_pc    = head_s.pc;
      fetch_err   = head_s.err;
    end else begin
      fetch_instr = '0;
      fetch_pc    = '0;
      fetch_err   = 1'b0;
    end
  end

  // Fetch PC and sticky error stop
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_r       <= RESET_PC;
      err_stop_r <= 1'b0;
    end else if (redirect_valid) begin
      pc_r       <= redirect_pc & ~ADDR_W'(3);
      err_stop_r <= 1'b0;
    end else if (xfer_s) begin
      pc_r       <= pc_r + ADDR_W'(4);
      err_stop_r <= err_stop_r | imem_err;
    end else begin
      pc_r       <= pc_r;
      err_stop_r <= err_stop_r;
    end
  end

endmodule

// File: doc/risc_v_prefetch_buffer.md
Name: risc_v_prefetch_buffer

Overview:
Parametrised instruction-fetch front end for the RV32I core. It replaces the core's single-request fetch with a decoupled prefetcher: a fetch PC, a DEPTH-entry instruction FIFO, redirect/flush on branch or jump, and sticky fetch-error propagation. It sits between the instruction memory port and the core decode stage, and lets the core consume one instruction per cycle while fetch runs ahead.

Parameters:
DEPTH, 4, FIFO entries; power of 2, minimum 2
ADDR_W, 32, fetch address width
DATA_W, 32, instruction width
RESET_PC, 32'h0000_0000, fetch PC after reset; bits [1:0] must be 0

Ports:
clk  in  1  clock; all logic on the rising edge
rst  in  1  asynchronous, active-high reset
fetch_enable  in  1  permits new imem requests
halt  in  1  core sleeping (WFI) or in debug; suppresses new requests
redirect_valid  in  1  branch/jump/trap taken this cycle
redirect_pc  in  ADDR_W  new fetch target
imem_req  out  1  instruction memory request
imem_addr  out  ADDR_W  request address (word aligned)
imem_rdata  in  DATA_W  response data; valid when imem_req && imem_ready
imem_ready  in  1  request accepted and data returned this cycle
imem_err  in  1  bus error on the accepted request
fetch_valid  out  1  FIFO head holds an instruction
fetch_instr  out  DATA_W  head instruction
fetch_pc  out  ADDR_W  PC of head instruction
fetch_err  out  1  head entry carries a fetch error
fetch_ready  in  1  core pops the head this cycle
fifo_count  out  $clog2(DEPTH)+1  occupancy, for debug and performance counters

Behaviour:
- Reset (async, rst=1):
  - FIFO empty; pointers 0; fetch PC = RESET_PC; err_stop = 0.
  - Outputs: imem_req=0, imem_addr=RESET_PC, fetch_valid=0, fetch_instr=0, fetch_pc=0, fetch_err=0, fifo_count=0.
  - Reset mid-transfer drops any in-flight response.
- Request rule:
  - imem_req = fetch_enable && !halt && !err_stop && !redirect_valid && (count < DEPTH).
  - Occupancy uses registered count only; a same-cycle pop does not free a slot (no ready-to-req combinational path).
  - imem_addr = fetch PC register.
- Handshake:
  - A transfer occurs when imem_req && imem_ready.
  - On transfer: push {fetch PC, imem_rdata, imem_err}; fetch PC += 4, wrapping 0xFFFF_FFFC -> 0 (modulo 2^ADDR_W).
  - imem_req holds with a stable address until imem_ready.
- Error:
  - A transfer with imem_err=1 pushes its entry with err=1 and sets err_stop.
  - No further requests until a redirect.
  - Entries already in the FIFO stay valid.
- Output:
  - fetch_valid = (count != 0); head fields come from FIFO registers with no bypass.
  - Latency from imem transfer to fetch_valid is 1 cycle.
  - Pop when fetch_valid && fetch_ready; fetch_ready while empty is ignored.
  - Head fields read 0 when the FIFO is empty.
- Simultaneous push and pop: count unchanged; both pointers advance modulo DEPTH.
- Redirect (highest priority):
  - In the redirect cycle, pop and push are ignored and imem_req is forced to 0.
  - Next cycle: FIFO empty, fetch PC = {redirect_pc[ADDR_W-1:2], 2'b00}, err_stop cleared.
  - Requests resume the cycle after redirect when permitted.
- halt or fetch_enable low: requests stop; FIFO contents and fetch PC are retained; fetch_valid/pop behaviour is unchanged.
- Full FIFO: no request; fetch PC holds.

Decomposition:
- Package risc_v_pkg holds:
  - fetch_entry_t struct {pc, instr, err}
  - RESET_PC default
  - NOP_INSTR constant (32'h0000_0013)
- One sub-module: prefetch_fifo, a generic synchronous FIFO parametrised by DEPTH and entry type, with flush, push, pop, count, full and empty.

Test Plan:
- Reset, fetch_enable=1, imem_ready=1, fetch_ready=0, DEPTH=4 -> addresses 0x0,0x4,0x8,0xC are requested; imem_req drops; fifo_count=4; head pc=0x0.
- Steady stream with fetch_ready=1 and imem_ready=1 -> one pop per cycle, fifo_count stays 1, fetch_pc increments by 4 every cycle.
- Redirect to 0x0000_0102 with 3 entries queued -> next cycle fifo_count=0, fetch_valid=0, imem_addr=0x0000_0100; first popped pc=0x100.
- imem_err=1 on the 0x8 transfer -> that entry pops with fetch_err=1; imem_req stays 0 until a redirect, then fetch resumes.
- halt=1 for 5 cycles mid-stream -> no requests; queued entries still pop; on halt=0 fetch resumes at the retained PC.
- Fetch PC = 0xFFFF_FFFC with a transfer -> next imem_addr=0x0000_0000; rst asserted during a stalled request -> all outputs return to reset values asynchronously.
